ccff_chain_loader: RTL and testbench

- Transmitter end of the configuration-chain (ccff) protocol.
- Accepts bitstream words over a valid/ready stream and serialises them onto a chain's ccff_head, qualified by config_enable, in the prog_clock domain.
- Sits between the bitstream source and the head of a logic-block configuration chain, e.g. the frac_lut6 / mux_wrap chain. Counts exactly CHAIN_LEN bits and reports completion.

---
 rtl/ccff_chain_loader_if.sv | 21 ++
 rtl/ccff_chain_loader.sv | 178 +++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between a source and ccff_chain_loader.
// master: bitstream source; slave: the loader.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
) ();
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words onto a configuration chain head.
// Words arrive MSB first over a valid/ready stream; exactly CHAIN_LEN enabled
// shift cycles are produced per load, then done pulses for one cycle.
// Optional readback check: define CCFF_CHAIN_LOADER_READBACK_EN to add a VERIFY
// pass that recirculates the chain once and compares CRC-16-CCITT signatures.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 65,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = 13
) (
  input  logic               prog_clock,
  input  logic               prog_reset_n,
  input  logic               start,
  ccff_chain_loader_if.slave word_if,
  output logic               ccff_head,
  output logic               config_enable,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               chk_err
);

  localparam int unsigned      RemW      = $clog2(WORD_W) + 1;
  localparam logic [CNT_W-1:0] ChainLenC = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] OneC      = CNT_W'(1);
  localparam logic [CNT_W-1:0] FirstRem  = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StVerify} state_e;

  state_e            state_q, state_d;
  // SHIFT: bits already driven onto the head; VERIFY: recirculation cycles done.
  logic [CNT_W-1:0]  sent_q, sent_d;
  // Bits still waiting in the buffer (0 = buffer empty).
  logic [RemW-1:0]   rem_q, rem_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  left;
  logic              accept;

  assign word_if.word_ready = (state_q == StShift) && (rem_q == '0) && (sent_q < ChainLenC);
  assign accept             = word_if.word_valid && word_if.word_ready;
  // Bits of the chain still to be filled after the one driven from a new word.
  assign left               = ChainLenC - sent_q - OneC;

  assign config_enable = en_q;
  assign done          = done_q;
  assign busy          = (state_q != StIdle);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [15:0] crc_tx_q, crc_tx_d;
  logic [15:0] crc_rb_q, crc_rb_d;
  logic        chk_q, chk_d;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Recirculate tail to head while verifying so the chain ends up unchanged.
  assign ccff_head = (state_q == StVerify) ? ccff_tail : head_q;
  assign chk_err   = chk_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_q;
  assign chk_err     = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    head_d  = head_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    crc_tx_d = crc_tx_q;
    crc_rb_d = crc_rb_q;
    chk_d    = chk_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          sent_d  = '0;
          rem_d   = '0;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          crc_tx_d = 16'hFFFF;
          crc_rb_d = 16'hFFFF;
          chk_d    = 1'b0;
`endif
        end
      end
      StShift: begin
        if (rem_q != '0) begin
          head_d = buf_q[WORD_W-1];
          buf_d  = buf_q << 1;
          rem_d  = rem_q - RemW'(1);
          en_d   = 1'b1;
          sent_d = sent_q + OneC;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          crc_tx_d = crc_step(crc_tx_q, buf_q[WORD_W-1]);
`endif
        end else if (accept) begin
          head_d = word_if.word_data[WORD_W-1];
          buf_d  = word_if.word_data << 1;
          // Last word may be partial: its unused low bits are simply never driven.
          rem_d  = (left < FirstRem) ? RemW'(left) : RemW'(WORD_W - 1);
          en_d   = 1'b1;
          sent_d = sent_q + OneC;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          crc_tx_d = crc_step(crc_tx_q, word_if.word_data[WORD_W-1]);
`endif
        end else if (sent_q == ChainLenC) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
          state_d = StVerify;
          sent_d  = '0;
          en_d    = 1'b1;
`else
          state_d = StIdle;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      StVerify: begin
        crc_rb_d = crc_step(crc_rb_q, ccff_tail);
        sent_d   = sent_q + OneC;
        if (sent_q == ChainLenC - OneC) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (crc_rb_d != crc_tx_q) chk_d = 1'b1;
        end else begin
          en_d = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= StIdle;
      sent_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      crc_tx_q <= '0;
      crc_rb_q <= '0;
      chk_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      head_q  <= head_d;
      en_q    <= en_d;
      done_q  <= done_d;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      crc_tx_q <= crc_tx_d;
      crc_rb_q <= crc_rb_d;
      chk_q    <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: a behavioural chain model plus a
// word-level reference of the expected chain image, with random words and gaps.
module tb_ccff_chain_loader;
  localparam int L  = 65;
  localparam int W  = 8;
  localparam int NW = (L + W - 1) / W;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  localparam int LTOT = 2 * L;
`else
  localparam int LTOT = L;
`endif

  logic prog_clock = 1'b0;
  logic prog_reset_n = 1'b0;
  logic start = 1'b0;
  logic ccff_head, config_enable, ccff_tail, busy, done, chk_err;
  logic start_s = 1'b0;
  logic tail_s = 1'b0;
  logic head_s, en_s, busy_s, done_s, chk_s;

  ccff_chain_loader_if #(.WORD_W(W)) m_if ();
  ccff_chain_loader_if #(.WORD_W(1)) s_if ();

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(13)) dut (
    .prog_clock   (prog_clock),
    .prog_reset_n (prog_reset_n),
    .start        (start),
    .word_if      (m_if),
    .ccff_head    (ccff_head),
    .config_enable(config_enable),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .chk_err      (chk_err)
  );

  ccff_chain_loader #(.CHAIN_LEN(2), .WORD_W(1), .CNT_W(2)) dut_small (
    .prog_clock   (prog_clock),
    .prog_reset_n (prog_reset_n),
    .start        (start_s),
    .word_if      (s_if),
    .ccff_head    (head_s),
    .config_enable(en_s),
    .ccff_tail    (tail_s),
    .busy         (busy_s),
    .done         (done_s),
    .chk_err      (chk_s)
  );

  always #5 prog_clock = ~prog_clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural chain: index 0 is the head end, index L-1 the tail.
  logic [L-1:0] chain = '0;
  logic [L-1:0] stuck_mask = '1;
  assign ccff_tail = chain[L-1];
  always @(posedge prog_clock) begin
    if (config_enable) chain <= {chain[L-2:0], ccff_head} & stuck_mask;
  end

  // Monitor: sample mid-cycle, counters only ever increase.
  int cyc = 0, hs_cnt = 0, en_cnt = 0, done_cnt = 0, done_cyc = 0, head_unstable = 0;
  logic prev_head = 1'b0;
  logic busy_at_done = 1'b0;
  bit seen[$];
  bit tails[$];
  int en_cyc[$];
  initial forever begin
    @(negedge prog_clock);
    cyc++;
    if (m_if.word_valid && m_if.word_ready) hs_cnt++;
    if (config_enable) begin
      en_cnt++;
      seen.push_back(ccff_head);
      tails.push_back(ccff_tail);
      en_cyc.push_back(cyc);
    end else if (busy && ccff_head !== prev_head) begin
      head_unstable++;
    end
    prev_head = ccff_head;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  // Source driver: presents words in order, with optional stall and random gaps.
  logic [W-1:0] words[NW];
  bit driving = 0;
  bit rand_valid = 0;
  int hs_base = 0, stall_at = -1, stall_left = 0;
  initial begin
    m_if.word_valid = 1'b0;
    m_if.word_data  = '0;
    forever begin
      @(posedge prog_clock);
      #1;
      if (!driving || (hs_cnt - hs_base) >= NW) begin
        m_if.word_valid = 1'b0;
      end else if ((hs_cnt - hs_base) == stall_at && stall_left > 0) begin
        m_if.word_valid = 1'b0;
        if (m_if.word_ready) stall_left--;
      end else if (rand_valid && $urandom_range(3) == 0) begin
        m_if.word_valid = 1'b0;
      end else begin
        m_if.word_valid = 1'b1;
        m_if.word_data  = words[hs_cnt - hs_base];
      end
    end
  end

  function automatic logic [15:0] crc_bits(input bit q[$], input int from, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ q[from+i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [L-1:0] exp_image();
    logic [L-1:0] e;
    logic [W-1:0] w;
    for (int i = 0; i < L; i++) begin
      w = words[i / W];
      e[L-1-i] = w[W-1-(i % W)];
    end
    return e;
  endfunction

  task automatic run_load(input string nm, input int stall_k, input int stall_n, input bit rnd,
                          input bit restart, input int rst_bits, input bit chk_img);
    int hs0, en0, dn0, sb0, un0, t;
    bit restarted, aborted;
    logic [L-1:0] got_s;
    logic [L-1:0] exp_s;
    hs0 = hs_cnt; en0 = en_cnt; dn0 = done_cnt; sb0 = seen.size(); un0 = head_unstable;
    restarted = 0; aborted = 0;
    hs_base = hs0; stall_at = stall_k; stall_left = stall_n; rand_valid = rnd; driving = 1;
    @(posedge prog_clock); #1 start = 1'b1;
    @(posedge prog_clock); #1 start = 1'b0;
    @(negedge prog_clock); #2;
    check({nm, ".busy_start"}, {busy, chk_err}, 2'b10);
    t = 0;
    while (done_cnt == dn0 && t < 3000 && !aborted) begin
      @(negedge prog_clock); #2;
      t++;
      if (restart && !restarted && hs_cnt - hs0 == 5) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      if (rst_bits > 0 && en_cnt - en0 == rst_bits) begin
        prog_reset_n = 1'b0;
        #1;
        check({nm, ".rst_outs"},
              {ccff_head, config_enable, busy, done, m_if.word_ready, chk_err}, 6'b0);
        driving = 0;
        @(negedge prog_clock); #2 prog_reset_n = 1'b1;
        repeat (2) @(negedge prog_clock);
        aborted = 1;
      end
    end
    start = 1'b0;
    if (aborted) return;
    driving = 0;
    check({nm, ".timeout"}, (done_cnt > dn0), 1'b1);
    if (done_cnt == dn0) return;
    repeat (3) @(negedge prog_clock);
    #2;
    check({nm, ".handshakes"}, hs_cnt - hs0, NW);
    check({nm, ".enables"}, en_cnt - en0, LTOT);
    check({nm, ".done_cnt"}, done_cnt - dn0, 1);
    check({nm, ".done_lat"}, done_cyc - en_cyc[sb0+LTOT-1], 1);
    check({nm, ".busy_at_done"}, busy_at_done, 1'b0);
    check({nm, ".head_stable"}, head_unstable - un0, 0);
    exp_s = exp_image();
    for (int i = 0; i < L; i++) got_s[L-1-i] = seen[sb0+i];
    check({nm, ".stream"}, got_s, exp_s);
    if (chk_img) check({nm, ".image"}, chain, exp_s);
    if (!rnd) check({nm, ".span"}, en_cyc[sb0+L-1] - en_cyc[sb0], L - 1 + stall_n);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    check({nm, ".vspan"}, en_cyc[sb0+LTOT-1] - en_cyc[sb0], LTOT - 1 + stall_n);
    check({nm, ".chk_err"}, chk_err,
          crc_bits(seen, sb0, L) != crc_bits(tails, sb0 + L, L));
`endif
  endtask

  initial begin
    int shs, acc, dc, sen;
    logic [1:0] sb;
    logic [1:0] sgot;
    s_if.word_valid = 1'b0;
    s_if.word_data  = '0;
    repeat (3) @(negedge prog_clock);
    check("reset_outs", {ccff_head, config_enable, busy, done, m_if.word_ready, chk_err}, 6'b0);
    #2 prog_reset_n = 1'b1;
    repeat (2) @(negedge prog_clock);

    for (int i = 0; i < NW; i++) words[i] = W'(8'hA5 + i);
    run_load("cont", -1, 0, 0, 0, 0, 1);
    run_load("stall", 4, 3, 0, 0, 0, 1);
    run_load("restart", -1, 0, 0, 1, 0, 1);
    run_load("rstmid", -1, 0, 0, 0, 30, 1);
    run_load("reload", -1, 0, 0, 0, 0, 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
      run_load($sformatf("rnd%0d", r), $urandom_range(NW - 1), $urandom_range(4), 1, 0, 0, 1);
    end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    for (int i = 0; i < NW; i++) words[i] = W'(8'hA5 + i);
    run_load("rb_clean", -1, 0, 0, 0, 0, 1);
    // Word 0xA5 lands at chain[L-1..L-8]; chain[L-1] holds a 1.
    stuck_mask = '1;
    stuck_mask[L-1] = 1'b0;
    run_load("rb_stuck", -1, 0, 0, 0, 0, 0);
    repeat (5) @(negedge prog_clock);
    check("rb_sticky", chk_err, 1'b1);
    stuck_mask = '1;
    run_load("rb_after", -1, 0, 0, 0, 0, 1);
`endif

    // Two-bit chain with one-bit words.
    sb = 2'($urandom);
    shs = 0; acc = -1; dc = -1; sen = 0; sgot = '0;
    @(posedge prog_clock); #1 start_s = 1'b1;
    @(posedge prog_clock); #1 start_s = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_if.word_valid = (shs < 2);
      s_if.word_data  = (shs == 0) ? sb[1] : sb[0];
      @(negedge prog_clock);
      if (s_if.word_valid && s_if.word_ready) begin
        if (acc < 0) acc = c;
        shs++;
      end
      if (en_s) begin
        if (sen < 2) sgot[1-sen] = head_s;
        sen++;
      end
      if (done_s && dc < 0) dc = c;
      @(posedge prog_clock); #1;
    end
    s_if.word_valid = 1'b0;
    check("small.handshakes", shs, 2);
    check("small.enables", sen, 2);
    check("small.done_lat", dc - acc, 3);
    check("small.bits", sgot, sb);
    check("small.busy", busy_s, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
